edge_trig_ctrl: RTL and testbench

Controller that sequences the `mov_sum` moving-sum HLS core for the ChipWhisperer edge trigger. It latches the trigger configuration on arm and issues `ap_start`. It converts raw offset-binary ADC samples to signed form and buffers them into the core's FIFO-style input, then compares each valid moving sum against a threshold to produce a trigger pulse. It sits between the ADC capture path and the trigger mux.

---
 rtl/edge_trig_pkg.sv | 31 +++
 rtl/edge_sample_fifo.sv | 75 +++++++
 rtl/edge_trig_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_edge_trig_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_trig_pkg.sv
// edge_trig_pkg: shared types and constants for the edge-trigger controller.
// Holds the controller state enum, default parameter values, field widths
// and a helper that maps a zero window length onto one.
package edge_trig_pkg;

  localparam int unsigned ADC_W_DEF       = 10;
  localparam int unsigned SUM_W_DEF       = 32;
  localparam int unsigned ADC_OFFSET_DEF  = 512;
  localparam int unsigned FIFO_DEPTH_DEF  = 4;

  localparam int unsigned WIN_W           = 8;
  localparam int unsigned HOLDOFF_W       = 16;
  localparam int unsigned TRIG_CNT_W      = 16;
  localparam int unsigned CORE_RST_CYCLES = 2;
  localparam int unsigned RST_CNT_W       = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET_CORE,
    ST_START,
    ST_FILL,
    ST_RUN,
    ST_HOLD
  } state_t;

  // A window of zero would never finish filling; treat it as one.
  function automatic logic [WIN_W-1:0] eff_window(input logic [WIN_W-1:0] w);
    return (w == '0) ? WIN_W'(1) : w;
  endfunction

endpackage

// File: rtl/edge_sample_fifo.sv
// edge_sample_fifo: small synchronous FIFO feeding the moving-sum core.
// Ports: clk/rst_n (async active-low), flush (drop all entries), push/din,
// pop, dout (head entry), empty_n (registered non-empty flag),
// drop_c (combinational: a push was refused because the FIFO is full).
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module edge_sample_fifo #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty_n,
  output logic         drop_c
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic             full_c;
  logic             pop_ok_c;
  logic             push_ok_c;

  assign full_c    = (count_q == CNT_W'(DEPTH));
  assign pop_ok_c  = pop && (count_q != '0);
  assign push_ok_c = push && (!full_c || pop_ok_c);
  assign drop_c    = push && !push_ok_c && !flush;
  assign dout      = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = count_q;
    if (push_ok_c && !pop_ok_c) begin
      count_nxt = count_q + CNT_W'(1);
    end else if (!push_ok_c && pop_ok_c) begin
      count_nxt = count_q - CNT_W'(1);
    end
  end

  // Storage, pointers and flags; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_n <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_n <= 1'b0;
    end else begin
      if (push_ok_c) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_nxt;
      empty_n <= (count_nxt != '0);
    end
  end

endmodule

// File: rtl/edge_trig_ctrl.sv
// edge_trig_ctrl: sequences the mov_sum moving-sum core for the edge trigger.
// On arm it latches the trigger configuration, resets and starts the core,
// streams offset-corrected ADC samples through a small FIFO into the core and
// compares each valid moving sum against the latched signed threshold.
// Ports: ap_clk/ap_rst_n (async active-low); arm/disarm pulses; cfg_* session
// configuration; adc_data/adc_valid sample input; ms_* core handshake and data;
// trig_out (one-cycle pulse), armed, overflow (sticky), trig_count (saturating).
// Build option: define EDGE_TRIG_CTRL_HOLDOFF_EN to re-arm after cfg_holdoff
// valid sums; otherwise the block is one-shot per session.
module edge_trig_ctrl
  import edge_trig_pkg::*;
#(
  parameter int unsigned ADC_W      = ADC_W_DEF,
  parameter int unsigned SUM_W      = SUM_W_DEF,
  parameter int unsigned ADC_OFFSET = ADC_OFFSET_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  arm,
  input  logic                  disarm,
  input  logic [WIN_W-1:0]      cfg_window_width,
  input  logic                  cfg_absolute,
  input  logic [SUM_W-1:0]      cfg_threshold,
  input  logic [HOLDOFF_W-1:0]  cfg_holdoff,
  input  logic [ADC_W-1:0]      adc_data,
  input  logic                  adc_valid,
  output logic                  ms_ap_rst,
  output logic                  ms_ap_start,
  input  logic                  ms_ap_done,
  input  logic                  ms_ap_idle,
  input  logic                  ms_ap_ready,
  output logic [WIN_W-1:0]      ms_window_width_V,
  output logic                  ms_absolute_value_V,
  output logic [ADC_W-1:0]      ms_datain_V_dout,
  output logic                  ms_datain_V_empty_n,
  input  logic                  ms_datain_V_read,
  input  logic [SUM_W-1:0]      ms_sumout_V,
  input  logic                  ms_sumout_V_ap_vld,
  output logic                  trig_out,
  output logic                  armed,
  output logic                  overflow,
  output logic [TRIG_CNT_W-1:0] trig_count
);

  state_t               state;
  logic [RST_CNT_W-1:0] rst_cnt;
  logic [WIN_W-1:0]     fill_cnt;
  logic [SUM_W-1:0]     thr_q;
  logic [ADC_W-1:0]     sample_c;
  logic                 sum_hit_c;
  logic                 fifo_flush_c;
  logic                 fifo_push_c;
  logic                 fifo_drop_c;

`ifdef EDGE_TRIG_CTRL_HOLDOFF_EN
  logic [HOLDOFF_W-1:0] hold_q;
  logic [HOLDOFF_W-1:0] hold_cnt;
`else
  logic                 unused_holdoff;
  assign unused_holdoff = ^cfg_holdoff;
`endif

  // Offset-binary to two's complement: subtract at ADC_W+1 bits, keep the low ADC_W.
  assign sample_c = ADC_W'((ADC_W+1)'(adc_data) - (ADC_W+1)'(ADC_OFFSET));

  assign sum_hit_c    = ($signed(ms_sumout_V) >= $signed(thr_q));
  assign fifo_push_c  = adc_valid && armed;
  assign fifo_flush_c = (state == ST_IDLE) ? arm : disarm;

  edge_sample_fifo #(
    .W     (ADC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .flush   (fifo_flush_c),
    .push    (fifo_push_c),
    .pop     (ms_datain_V_read),
    .din     (sample_c),
    .dout    (ms_datain_V_dout),
    .empty_n (ms_datain_V_empty_n),
    .drop_c  (fifo_drop_c)
  );

  // Session FSM with registered core controls, trigger pulse and counters.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state               <= ST_IDLE;
      rst_cnt             <= '0;
      fill_cnt            <= '0;
      thr_q               <= '0;
      ms_ap_rst           <= 1'b0;
      ms_ap_start         <= 1'b0;
      ms_window_width_V   <= WIN_W'(1);
      ms_absolute_value_V <= 1'b0;
      trig_out            <= 1'b0;
      armed               <= 1'b0;
      overflow            <= 1'b0;
      trig_count          <= '0;
`ifdef EDGE_TRIG_CTRL_HOLDOFF_EN
      hold_q              <= '0;
      hold_cnt            <= '0;
`endif
    end else begin
      trig_out  <= 1'b0;
      ms_ap_rst <= 1'b0;
      if (fifo_drop_c) overflow <= 1'b1;

      // Abort wins over arm and over a same-cycle trigger.
      if (state != ST_IDLE && disarm) begin
        state       <= ST_IDLE;
        ms_ap_rst   <= 1'b1;
        ms_ap_start <= 1'b0;
        armed       <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (arm) begin
              ms_window_width_V   <= eff_window(cfg_window_width);
              ms_absolute_value_V <= cfg_absolute;
              thr_q               <= cfg_threshold;
`ifdef EDGE_TRIG_CTRL_HOLDOFF_EN
              hold_q              <= cfg_holdoff;
`endif
              overflow            <= 1'b0;
              trig_count          <= '0;
              rst_cnt             <= '0;
              ms_ap_rst           <= 1'b1;
              state               <= ST_RESET_CORE;
            end
          end
          ST_RESET_CORE: begin
            if (rst_cnt == RST_CNT_W'(CORE_RST_CYCLES - 1)) begin
              ms_ap_start <= 1'b1;
              armed       <= 1'b1;
              state       <= ST_START;
            end else begin
              rst_cnt   <= rst_cnt + RST_CNT_W'(1);
              ms_ap_rst <= 1'b1;
            end
          end
          ST_START: begin
            if (ms_ap_ready || !ms_ap_idle) begin
              ms_ap_start <= 1'b0;
              fill_cnt    <= '0;
              state       <= ST_FILL;
            end
          end
          ST_FILL: begin
            if (ms_ap_done) begin
              armed <= 1'b0;
              state <= ST_IDLE;
            end else if (ms_sumout_V_ap_vld) begin
              if (fill_cnt == ms_window_width_V - WIN_W'(1)) begin
                state <= ST_RUN;
              end else begin
                fill_cnt <= fill_cnt + WIN_W'(1);
              end
            end
          end
          ST_RUN: begin
            if (ms_ap_done) begin
              armed <= 1'b0;
              state <= ST_IDLE;
            end else if (ms_sumout_V_ap_vld && sum_hit_c) begin
              trig_out <= 1'b1;
              if (trig_count != '1) trig_count <= trig_count + TRIG_CNT_W'(1);
`ifdef EDGE_TRIG_CTRL_HOLDOFF_EN
              hold_cnt <= '0;
`endif
              state    <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (ms_ap_done) begin
              armed <= 1'b0;
              state <= ST_IDLE;
            end
`ifdef EDGE_TRIG_CTRL_HOLDOFF_EN
            else if (hold_q == '0) begin
              state <= ST_RUN;
            end else if (ms_sumout_V_ap_vld) begin
              if (hold_cnt == hold_q - HOLDOFF_W'(1)) begin
                state <= ST_RUN;
              end else begin
                hold_cnt <= hold_cnt + HOLDOFF_W'(1);
              end
            end
`endif
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_edge_trig_ctrl.sv
// tb_edge_trig_ctrl: directed self-checking bench for edge_trig_ctrl.
// The moving-sum core is stubbed by driving its status, read and sum ports.
module tb_edge_trig_ctrl;

`ifdef EDGE_TRIG_CTRL_HOLDOFF_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic        ap_clk;
  logic        ap_rst_n;
  logic        arm;
  logic        disarm;
  logic [7:0]  cfg_window_width;
  logic        cfg_absolute;
  logic [31:0] cfg_threshold;
  logic [15:0] cfg_holdoff;
  logic [9:0]  adc_data;
  logic        adc_valid;
  logic        ms_ap_rst;
  logic        ms_ap_start;
  logic        ms_ap_done;
  logic        ms_ap_idle;
  logic        ms_ap_ready;
  logic [7:0]  ms_window_width_V;
  logic        ms_absolute_value_V;
  logic [9:0]  ms_datain_V_dout;
  logic        ms_datain_V_empty_n;
  logic        ms_datain_V_read;
  logic [31:0] ms_sumout_V;
  logic        ms_sumout_V_ap_vld;
  logic        trig_out;
  logic        armed;
  logic        overflow;
  logic [15:0] trig_count;

  int n_pass  = 0;
  int n_total = 0;

  edge_trig_ctrl dut (
    .ap_clk              (ap_clk),
    .ap_rst_n            (ap_rst_n),
    .arm                 (arm),
    .disarm              (disarm),
    .cfg_window_width    (cfg_window_width),
    .cfg_absolute        (cfg_absolute),
    .cfg_threshold       (cfg_threshold),
    .cfg_holdoff         (cfg_holdoff),
    .adc_data            (adc_data),
    .adc_valid           (adc_valid),
    .ms_ap_rst           (ms_ap_rst),
    .ms_ap_start         (ms_ap_start),
    .ms_ap_done          (ms_ap_done),
    .ms_ap_idle          (ms_ap_idle),
    .ms_ap_ready         (ms_ap_ready),
    .ms_window_width_V   (ms_window_width_V),
    .ms_absolute_value_V (ms_absolute_value_V),
    .ms_datain_V_dout    (ms_datain_V_dout),
    .ms_datain_V_empty_n (ms_datain_V_empty_n),
    .ms_datain_V_read    (ms_datain_V_read),
    .ms_sumout_V         (ms_sumout_V),
    .ms_sumout_V_ap_vld  (ms_sumout_V_ap_vld),
    .trig_out            (trig_out),
    .armed               (armed),
    .overflow            (overflow),
    .trig_count          (trig_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    ap_rst_n = 1'b0; arm = 1'b0; disarm = 1'b0;
    cfg_window_width = 8'd3; cfg_absolute = 1'b1; cfg_threshold = 32'd100; cfg_holdoff = 16'd5;
    adc_data = '0; adc_valid = 1'b0;
    ms_ap_done = 1'b0; ms_ap_idle = 1'b1; ms_ap_ready = 1'b0;
    ms_datain_V_read = 1'b0; ms_sumout_V = '0; ms_sumout_V_ap_vld = 1'b0;

    tick(); tick();
    chk("rst_armed", armed, 0);
    chk("rst_win", ms_window_width_V, 1);
    chk("rst_start", ms_ap_start, 0);
    chk("rst_core_rst", ms_ap_rst, 0);
    chk("rst_empty_n", ms_datain_V_empty_n, 0);
    chk("rst_trig_count", trig_count, 0);
    ap_rst_n = 1'b1;
    tick();

    // Session 1: window 3, threshold 100, holdoff 5
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_core_rst1", ms_ap_rst, 1);
    chk("arm_start_low", ms_ap_start, 0);
    chk("arm_win", ms_window_width_V, 3);
    chk("arm_abs", ms_absolute_value_V, 1);
    chk("arm_armed_low", armed, 0);
    cfg_threshold = 32'd0; cfg_window_width = 8'd7; cfg_absolute = 1'b0;
    tick();
    chk("arm_core_rst2", ms_ap_rst, 1);
    tick();
    chk("arm_core_rst_end", ms_ap_rst, 0);
    chk("arm_start_high", ms_ap_start, 1);
    chk("arm_armed", armed, 1);
    tick();
    chk("start_hold", ms_ap_start, 1);
    ms_ap_ready = 1'b1;
    tick();
    ms_ap_ready = 1'b0;
    chk("start_drop", ms_ap_start, 0);

    // Sample conversion
    adc_data = 10'd0; adc_valid = 1'b1;
    tick();
    chk("conv_0", ms_datain_V_dout, 10'h200);
    chk("conv_0_nonempty", ms_datain_V_empty_n, 1);
    adc_data = 10'd1023; ms_datain_V_read = 1'b1;
    tick();
    chk("conv_1023", ms_datain_V_dout, 10'h1FF);
    adc_valid = 1'b0;
    tick();
    chk("drain_empty", ms_datain_V_empty_n, 0);
    tick();
    chk("read_empty_ignored", ms_datain_V_empty_n, 0);
    ms_datain_V_read = 1'b0;

    // FILL: three sums above threshold must not trigger
    ms_sumout_V_ap_vld = 1'b1; ms_sumout_V = 32'd300;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fill_no_trig", trig_out, 0);
    end
    ms_sumout_V = 32'hFFFF_FF00;
    tick();
    chk("neg_sum_no_trig", trig_out, 0);
    ms_sumout_V = 32'd99;
    tick();
    chk("sum99_no_trig", trig_out, 0);
    ms_sumout_V = 32'd100;
    tick();
    chk("sum100_trig", trig_out, 1);
    chk("trig_count_1", trig_count, 1);
    ms_sumout_V_ap_vld = 1'b0;
    tick();
    chk("trig_one_cycle", trig_out, 0);

    // HOLD: re-triggers every 6th sum with holdoff 5, never in one-shot mode
    ms_sumout_V_ap_vld = 1'b1; ms_sumout_V = 32'd1000;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("hold_trig", trig_out, 32'(HOLD_EN && (i % 6 == 0)));
    end
    ms_sumout_V_ap_vld = 1'b0;
    tick();
    chk("hold_trig_count", trig_count, HOLD_EN ? 32'd3 : 32'd1);

    // FIFO full / overflow / ordering
    adc_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      adc_data = 10'(i * 10);
      tick();
    end
    chk("full_no_ovf", overflow, 0);
    adc_data = 10'd50; ms_datain_V_read = 1'b1;
    tick();
    chk("full_push_pop_no_ovf", overflow, 0);
    chk("full_push_pop_head", ms_datain_V_dout, 10'h214);
    adc_data = 10'd60; ms_datain_V_read = 1'b0;
    tick();
    adc_valid = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_head", ms_datain_V_dout, 10'h214);
    ms_datain_V_read = 1'b1;
    tick();
    chk("order_s3", ms_datain_V_dout, 10'h21E);
    tick();
    chk("order_s4", ms_datain_V_dout, 10'h228);
    tick();
    chk("order_s5", ms_datain_V_dout, 10'h232);
    tick();
    chk("order_empty", ms_datain_V_empty_n, 0);
    ms_datain_V_read = 1'b0;

    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    chk("disarm1_armed", armed, 0);
    chk("disarm1_core_rst", ms_ap_rst, 1);
    tick();
    chk("disarm1_core_rst_end", ms_ap_rst, 0);

    // Session 2: window 1, threshold -10, start via ap_idle low
    cfg_window_width = 8'd1; cfg_threshold = 32'hFFFF_FFF6; cfg_holdoff = 16'd0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm2_ovf_clear", overflow, 0);
    chk("arm2_count_clear", trig_count, 0);
    tick(); tick();
    chk("arm2_start", ms_ap_start, 1);
    ms_ap_idle = 1'b0;
    tick();
    ms_ap_idle = 1'b1;
    chk("arm2_idle_low_ack", ms_ap_start, 0);
    ms_sumout_V_ap_vld = 1'b1; ms_sumout_V = 32'hFFFF_FFEC;
    tick();
    chk("s2_fill_no_trig", trig_out, 0);
    ms_sumout_V = 32'hFFFF_FFF5;
    adc_valid = 1'b1; adc_data = 10'd600;
    tick();
    adc_valid = 1'b0;
    chk("s2_minus11_no_trig", trig_out, 0);
    chk("s2_buffered", ms_datain_V_empty_n, 1);
    ms_sumout_V = 32'hFFFF_FFF7; disarm = 1'b1;
    tick();
    disarm = 1'b0; ms_sumout_V_ap_vld = 1'b0;
    chk("disarm_beats_trig", trig_out, 0);
    chk("disarm2_armed", armed, 0);
    chk("disarm2_core_rst", ms_ap_rst, 1);
    chk("disarm2_flush", ms_datain_V_empty_n, 0);
    tick();

    // Session 3: async reset mid-RUN
    cfg_window_width = 8'd2; cfg_threshold = 32'd0; cfg_absolute = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick(); tick();
    ms_ap_ready = 1'b1;
    tick();
    ms_ap_ready = 1'b0;
    adc_valid = 1'b1; adc_data = 10'd700;
    ms_sumout_V_ap_vld = 1'b1; ms_sumout_V = 32'd1;
    tick();
    adc_valid = 1'b0;
    tick();
    ms_sumout_V_ap_vld = 1'b0;
    chk("s3_fill_no_trig", trig_out, 0);
    chk("s3_armed", armed, 1);
    chk("s3_buffered", ms_datain_V_empty_n, 1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("async_armed", armed, 0);
    chk("async_empty_n", ms_datain_V_empty_n, 0);
    chk("async_dout", ms_datain_V_dout, 0);
    chk("async_win", ms_window_width_V, 1);
    chk("async_abs", ms_absolute_value_V, 0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle_armed", armed, 0);
      chk("post_rst_idle_core_rst", ms_ap_rst, 0);
      chk("post_rst_idle_start", ms_ap_start, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
